switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Per-output switch allocator for the 5-port (L,N,E,W,S) NoC router.
- Arbitrates header flits from the five input buffers for each crossbar output with round-robin priority.
- Holds the grant (wormhole lock) until the tail flit transfers, or until a stall watchdog expires.
- Drives the crossbar select lines and per-input grants; sits between the input buffers and the crossbar.

Parameters:
- TIMEOUT, 64: consecutive cycles without a transfer on a locked output before the lock is forcibly released (range 2..4095).
- CNT_W, 12: watchdog counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  5  bit i: input i presents a valid flit (port index L=0, N=1, E=2, W=3, S=4).
- dest  in  15  bits [3i+2:3i]: output index requested by input i; values 5..7 are invalid.
- flit_id  in  15  bits [3i+2:3i]: flit type of input i; 3'b001 header, 3'b010 body, 3'b100 tail.
- out_ready  in  5  bit o: downstream of output o accepts a flit this cycle.
- grant  out  5  bit i: input i holds a lock on some output (registered).
- out_sel  out  15  bits [3o+2:3o]: input index driving output o; 3'b111 when idle.
- out_busy  out  5  bit o: output o locked.
- timeout_evt  out  5  bit o: one-cycle pulse when output o's lock is released by the watchdog.

Behaviour:
- Reset values: grant=0, out_sel=all 3'b111, out_busy=0, timeout_evt=0, rr_ptr[o]=0, counters=0. A reset asserted mid-packet drops every lock on the next edge; the partial packet is abandoned.
- Per-output FSM with states IDLE and LOCKED.
- IDLE, eligibility: input i is eligible for output o when all of the following hold:
  - req[i]=1
  - flit_id_i=3'b001
  - dest_i=o
  - grant[i]=0
- IDLE, arbitration: the winner is the first eligible input scanning rr_ptr[o], rr_ptr[o]+1, ... mod 5.
- IDLE, lock: at the clock edge out_busy[o]=1, out_sel[o]=winner, grant[winner]=1, counter cleared.
- Grant latency is one cycle: the header transfers in the cycle after arbitration at the earliest.
- IDLE: body/tail flits, invalid dest, and requests from already-granted inputs are never granted.
- LOCKED, transfer: a transfer occurs when req[owner]=1 and out_ready[o]=1. flit_id is not re-examined except for tail detection. A header on a locked input is treated as a body flit.
- LOCKED, tail release: a transfer with flit_id=3'b100 releases the lock at that edge:
  - out_busy[o]=0, out_sel[o]=3'b111, grant[owner]=0.
  - rr_ptr[o] = owner+1 mod 5.
  - Return to IDLE.
- LOCKED, watchdog: a cycle with no transfer increments the counter; a transfer clears it.
- LOCKED, watchdog release: when counter = TIMEOUT-1 and no transfer occurs, the lock is released as for a tail, and timeout_evt[o]=1 for exactly one cycle.
- Tail transfer in the same cycle the counter reaches TIMEOUT-1: treated as a normal tail release, timeout_evt stays 0.
- There is always at least one idle cycle between release and the next grant on the same output; a released output re-arbitrates in its first IDLE cycle.
- Independence: the five outputs arbitrate independently and in the same cycle. Since each input has one dest, no input can win two outputs; grant has at most one owner per output.
- dest changing on a locked input is ignored until release.
- Counter saturates at TIMEOUT-1 and never wraps.

Test Plan:
- Single packet, no contention: L header dest=E (2), then 2 body and a tail, out_ready=1.
  - Cycle+1: grant[0]=1, out_sel[E]=0, out_busy[2]=1.
  - Edge after the tail transfer: all return to reset values; rr_ptr[E]=1.
- Contention and round robin: N, W, S all send headers to output L every packet.
  - Grant order is N, W, S, N, each lock held to its own tail.
  - out_sel[L] sequence is 1, 3, 4, 1, with one idle cycle between locks.
- Backpressure: locked E→S with out_ready[4]=0 for 10 cycles, TIMEOUT=64.
  - Lock is held and timeout_evt=0.
  - After out_ready returns to 1, the transfer proceeds and the counter clears.
- Watchdog: a locked owner drops req for 64 cycles.
  - On the 64th stall cycle the lock is released and timeout_evt[o] pulses for one cycle.
  - A tail arriving on that 64th cycle instead gives a release with no pulse.
- Reset mid-packet: assert rst for 1 cycle during a body flit.
  - Next edge: grant=0, out_sel=all 7, out_busy=0.
  - Subsequent body flits without a header are never granted.
- Invalid/ineligible requests: dest=6 header, and a body flit to an idle output.
  - No grant is issued; other outputs are unaffected.

Source files
------------

// File: rtl/switch_allocator_if.sv
// Handshake bundle between the five input buffers, the switch allocator and the crossbar.
// Port index order everywhere: L=0, N=1, E=2, W=3, S=4.
//   req         : per-input valid flit
//   dest        : per-input 3-bit requested output index (5..7 invalid)
//   flit_id     : per-input 3-bit flit type (001 header, 010 body, 100 tail)
//   out_ready   : per-output downstream accept
//   grant       : per-input lock held (registered)
//   out_sel     : per-output 3-bit input index driving it, 3'b111 when idle
//   out_busy    : per-output locked
//   timeout_evt : per-output one-cycle pulse on a watchdog release
// master: the buffer/crossbar side; slave: the allocator.
interface switch_allocator_if;
    logic [4:0]  req;
    logic [14:0] dest;
    logic [14:0] flit_id;
    logic [4:0]  out_ready;
    logic [4:0]  grant;
    logic [14:0] out_sel;
    logic [4:0]  out_busy;
    logic [4:0]  timeout_evt;

    modport master (
        output req, dest, flit_id, out_ready,
        input  grant, out_sel, out_busy, timeout_evt
    );

    modport slave (
        input  req, dest, flit_id, out_ready,
        output grant, out_sel, out_busy, timeout_evt
    );
endinterface

// File: rtl/switch_allocator.sv
// Per-output switch allocator for a 5-port (L,N,E,W,S) wormhole NoC router.
// Each output runs an IDLE/LOCKED FSM: in IDLE it round-robin arbitrates header flits aimed at
// it, in LOCKED it holds the winner until a tail transfers or the stall watchdog expires.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset (drops every lock)
//   bus : switch_allocator_if.slave (requests in; grants, crossbar selects, busy, timeouts out)
module switch_allocator #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  bus
);

    localparam int unsigned NP = 5;

    localparam logic [0:0] StIdle   = 1'b0;
    localparam logic [0:0] StLocked = 1'b1;

    localparam logic [2:0] FlitHead = 3'b001;
    localparam logic [2:0] FlitTail = 3'b100;
    localparam logic [2:0] SelIdle  = 3'b111;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

    logic [NP-1:0]    state_q, state_d;
    logic [NP-1:0]    grant_q, grant_d;
    logic [NP-1:0]    tevt_q, tevt_d;
    logic [2:0]       owner_q [NP];
    logic [2:0]       owner_d [NP];
    logic [2:0]       rr_q    [NP];
    logic [2:0]       rr_d    [NP];
    logic [CNT_W-1:0] cnt_q   [NP];
    logic [CNT_W-1:0] cnt_d   [NP];

    // elig[o][i]: input i may win output o this cycle
    logic [NP-1:0]    elig [NP];

    always_comb begin
        for (int o = 0; o < NP; o++) begin
            elig[o] = '0;
            for (int i = 0; i < NP; i++) begin
                elig[o][i] = bus.req[i] && (bus.flit_id[3*i +: 3] == FlitHead) &&
                             (bus.dest[3*i +: 3] == 3'(o)) && !grant_q[i];
            end
        end
    end

    always_comb begin
        logic xfer;
        logic tail;
        logic found;
        int   own;
        int   idx;
        int   win;

        state_d = state_q;
        grant_d = grant_q;
        tevt_d  = '0;
        xfer    = 1'b0;
        tail    = 1'b0;
        found   = 1'b0;
        own     = 0;
        idx     = 0;
        win     = 0;

        for (int o = 0; o < NP; o++) begin
            owner_d[o] = owner_q[o];
            rr_d[o]    = rr_q[o];
            cnt_d[o]   = cnt_q[o];

            if (state_q[o] == StLocked) begin
                own  = int'(owner_q[o]);
                xfer = bus.req[own] && bus.out_ready[o];
                // Only tail detection looks at flit_id; a stray header counts as body.
                tail = (bus.flit_id[3*own +: 3] == FlitTail);
                if ((xfer && tail) || (!xfer && (cnt_q[o] == CntMax))) begin
                    state_d[o]   = StIdle;
                    grant_d[own] = 1'b0;
                    rr_d[o]      = (owner_q[o] == 3'd4) ? 3'd0 : owner_q[o] + 3'd1;
                    cnt_d[o]     = '0;
                    // A tail landing on the last allowed cycle is a normal release.
                    tevt_d[o]    = !xfer;
                end else if (xfer) begin
                    cnt_d[o] = '0;
                end else begin
                    cnt_d[o] = cnt_q[o] + 1'b1;
                end
            end else begin
                found = 1'b0;
                win   = 0;
                for (int k = 0; k < NP; k++) begin
                    idx = int'(rr_q[o]) + k;
                    if (idx >= NP) begin
                        idx = idx - NP;
                    end
                    if (!found && elig[o][idx]) begin
                        found = 1'b1;
                        win   = idx;
                    end
                end
                if (found) begin
                    state_d[o]   = StLocked;
                    owner_d[o]   = 3'(win);
                    grant_d[win] = 1'b1;
                    cnt_d[o]     = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            grant_q <= '0;
            tevt_q  <= '0;
            for (int o = 0; o < NP; o++) begin
                owner_q[o] <= '0;
                rr_q[o]    <= '0;
                cnt_q[o]   <= '0;
            end
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            tevt_q  <= tevt_d;
            for (int o = 0; o < NP; o++) begin
                owner_q[o] <= owner_d[o];
                rr_q[o]    <= rr_d[o];
                cnt_q[o]   <= cnt_d[o];
            end
        end
    end

    always_comb begin
        bus.grant       = grant_q;
        bus.out_busy    = state_q;
        bus.timeout_evt = tevt_q;
        bus.out_sel     = '1;
        for (int o = 0; o < NP; o++) begin
            bus.out_sel[3*o +: 3] = (state_q[o] == StLocked) ? owner_q[o] : SelIdle;
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    switch_allocator_if bus ();

    switch_allocator #(
        .TIMEOUT (64),
        .CNT_W   (12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam logic [2:0]  H = 3'b001;
    localparam logic [2:0]  B = 3'b010;
    localparam logic [2:0]  T = 3'b100;
    localparam logic [2:0]  Z = 3'b000;
    localparam logic [14:0] IDLE_SEL = 15'h7fff;
    localparam logic [4:0]  RDY_ALL  = 5'h1f;

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic [14:0] dest;
        logic [14:0] flit;
        logic [4:0]  rdy;
        logic [4:0]  grant;
        logic [14:0] sel;
        logic [4:0]  busy;
        logic [4:0]  tevt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [14:0] f3(input logic [2:0] a0, input logic [2:0] a1,
                                       input logic [2:0] a2, input logic [2:0] a3,
                                       input logic [2:0] a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [14:0] sel1(input int o, input logic [2:0] i);
        logic [14:0] s;
        s = IDLE_SEL;
        s[3*o +: 3] = i;
        return s;
    endfunction

    function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [14:0] d,
                                input logic [14:0] f, input logic [4:0] rdy,
                                input logic [4:0] eg, input logic [14:0] es,
                                input logic [4:0] eb, input logic [4:0] et);
        vec_t v;
        v.rst = r;  v.req = rq;  v.dest = d;  v.flit = f;  v.rdy = rdy;
        v.grant = eg;  v.sel = es;  v.busy = eb;  v.tevt = et;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rq, input logic [14:0] d,
                         input logic [14:0] f, input logic [4:0] rdy);
        rst           = r;
        bus.req       = rq;
        bus.dest      = d;
        bus.flit_id   = f;
        bus.out_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] eg, input logic [14:0] es,
                         input logic [4:0] eb, input logic [4:0] et);
        n_checks++;
        if (bus.grant !== eg || bus.out_sel !== es || bus.out_busy !== eb ||
            bus.timeout_evt !== et) begin
            n_fail++;
            $display("FAIL %s: got grant=%b out_sel=%h out_busy=%b timeout_evt=%b, want grant=%b out_sel=%h out_busy=%b timeout_evt=%b",
                     name, bus.grant, bus.out_sel, bus.out_busy, bus.timeout_evt,
                     eg, es, eb, et);
        end
    endtask

    initial begin
        // Reset, then single packet L -> E.
        vecs.push_back(mk(1, 5'b00000, '0, '0, RDY_ALL, 5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(H, Z, Z, Z, Z), RDY_ALL,
                          5'b00001, sel1(2, 0), 5'b00100, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(H, Z, Z, Z, Z), RDY_ALL,
                          5'b00001, sel1(2, 0), 5'b00100, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(B, Z, Z, Z, Z), RDY_ALL,
                          5'b00001, sel1(2, 0), 5'b00100, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(B, Z, Z, Z, Z), RDY_ALL,
                          5'b00001, sel1(2, 0), 5'b00100, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(T, Z, Z, Z, Z), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b00000, '0, '0, RDY_ALL, 5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        // rr_ptr[E] is now 1: L and N contend, N wins.
        vecs.push_back(mk(0, 5'b00011, f3(2, 2, 0, 0, 0), f3(H, H, Z, Z, Z), RDY_ALL,
                          5'b00010, sel1(2, 1), 5'b00100, 5'b0));
        vecs.push_back(mk(0, 5'b00011, f3(2, 2, 0, 0, 0), f3(H, T, Z, Z, Z), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(H, Z, Z, Z, Z), RDY_ALL,
                          5'b00001, sel1(2, 0), 5'b00100, 5'b0));
        vecs.push_back(mk(0, 5'b00001, f3(2, 0, 0, 0, 0), f3(T, Z, Z, Z, Z), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b00000, '0, '0, RDY_ALL, 5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        // N, W, S contend for L: order N, W, S, N.
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, H, H), RDY_ALL,
                          5'b00010, sel1(0, 1), 5'b00001, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, T, Z, H, H), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, H, H), RDY_ALL,
                          5'b01000, sel1(0, 3), 5'b00001, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, B, H), RDY_ALL,
                          5'b01000, sel1(0, 3), 5'b00001, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, T, H), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, H, H), RDY_ALL,
                          5'b10000, sel1(0, 4), 5'b00001, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, H, T), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, H, Z, H, H), RDY_ALL,
                          5'b00010, sel1(0, 1), 5'b00001, 5'b0));
        vecs.push_back(mk(0, 5'b11010, '0, f3(Z, T, Z, H, H), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b00000, '0, '0, RDY_ALL, 5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        // Invalid dest header and body to idle output ignored; E -> W locks.
        vecs.push_back(mk(0, 5'b00111, f3(6, 1, 3, 0, 0), f3(H, B, H, Z, Z), RDY_ALL,
                          5'b00100, sel1(3, 2), 5'b01000, 5'b0));
        // Header and new dest on locked E are ignored.
        vecs.push_back(mk(0, 5'b00111, f3(6, 1, 1, 0, 0), f3(H, B, H, Z, Z), RDY_ALL,
                          5'b00100, sel1(3, 2), 5'b01000, 5'b0));
        vecs.push_back(mk(0, 5'b00111, f3(6, 1, 1, 0, 0), f3(H, B, T, Z, Z), RDY_ALL,
                          5'b00000, IDLE_SEL, 5'b00000, 5'b0));
        vecs.push_back(mk(0, 5'b00000, '0, '0, RDY_ALL, 5'b00000, IDLE_SEL, 5'b00000, 5'b0));

        drive(1, '0, '0, '0, RDY_ALL);
        tick;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].dest, vecs[i].flit, vecs[i].rdy);
            tick;
            check($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].busy,
                  vecs[i].tevt);
        end

        // Backpressure on E -> S, then watchdog expiry.
        drive(0, 5'b00100, f3(0, 0, 4, 0, 0), f3(Z, Z, H, Z, Z), 5'b01111);
        tick;
        check("bp_lock", 5'b00100, sel1(4, 2), 5'b10000, 5'b0);
        for (int k = 0; k < 10; k++) begin
            drive(0, 5'b00100, f3(0, 0, 4, 0, 0), f3(Z, Z, B, Z, Z), 5'b01111);
            tick;
            check($sformatf("bp_hold%0d", k), 5'b00100, sel1(4, 2), 5'b10000, 5'b0);
        end
        drive(0, 5'b00100, f3(0, 0, 4, 0, 0), f3(Z, Z, B, Z, Z), RDY_ALL);
        tick;
        check("bp_resume", 5'b00100, sel1(4, 2), 5'b10000, 5'b0);
        for (int k = 1; k <= 63; k++) begin
            drive(0, 5'b00000, f3(0, 0, 4, 0, 0), f3(Z, Z, B, Z, Z), RDY_ALL);
            tick;
            check($sformatf("wd_stall%0d", k), 5'b00100, sel1(4, 2), 5'b10000, 5'b0);
        end
        drive(0, 5'b00000, f3(0, 0, 4, 0, 0), f3(Z, Z, B, Z, Z), RDY_ALL);
        tick;
        check("wd_release", 5'b00000, IDLE_SEL, 5'b00000, 5'b10000);
        tick;
        check("wd_pulse_end", 5'b00000, IDLE_SEL, 5'b00000, 5'b00000);

        // Tail arriving on the 64th stall cycle: plain release, no pulse.
        drive(0, 5'b00001, f3(1, 0, 0, 0, 0), f3(H, Z, Z, Z, Z), RDY_ALL);
        tick;
        check("tl_lock", 5'b00001, sel1(1, 0), 5'b00010, 5'b0);
        for (int k = 1; k <= 63; k++) begin
            drive(0, 5'b00000, f3(1, 0, 0, 0, 0), f3(B, Z, Z, Z, Z), RDY_ALL);
            tick;
        end
        check("tl_stall63", 5'b00001, sel1(1, 0), 5'b00010, 5'b0);
        drive(0, 5'b00001, f3(1, 0, 0, 0, 0), f3(T, Z, Z, Z, Z), RDY_ALL);
        tick;
        check("tl_release", 5'b00000, IDLE_SEL, 5'b00000, 5'b00000);
        drive(0, 5'b00000, '0, '0, RDY_ALL);
        tick;
        check("tl_after", 5'b00000, IDLE_SEL, 5'b00000, 5'b00000);

        // Reset mid-packet on W -> N; orphan body flits never win.
        drive(0, 5'b01000, f3(0, 0, 0, 1, 0), f3(Z, Z, Z, H, Z), RDY_ALL);
        tick;
        check("rst_lock", 5'b01000, sel1(1, 3), 5'b00010, 5'b0);
        drive(0, 5'b01000, f3(0, 0, 0, 1, 0), f3(Z, Z, Z, B, Z), RDY_ALL);
        tick;
        check("rst_body", 5'b01000, sel1(1, 3), 5'b00010, 5'b0);
        drive(1, 5'b01000, f3(0, 0, 0, 1, 0), f3(Z, Z, Z, B, Z), RDY_ALL);
        tick;
        check("rst_drop", 5'b00000, IDLE_SEL, 5'b00000, 5'b0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 5'b01000, f3(0, 0, 0, 1, 0), f3(Z, Z, Z, B, Z), RDY_ALL);
            tick;
            check($sformatf("rst_orphan%0d", k), 5'b00000, IDLE_SEL, 5'b00000, 5'b0);
        end
        drive(0, 5'b01000, f3(0, 0, 0, 1, 0), f3(Z, Z, Z, T, Z), RDY_ALL);
        tick;
        check("rst_orphan_tail", 5'b00000, IDLE_SEL, 5'b00000, 5'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
